// File: rtl/distram_nrport_1wport_clr.sv
// distram_nrport_1wport_clr: N async read ports, one sync write port, built-in bulk clear sequencer
module distram_nrport_1wport_clr #(
  parameter int OUTER_WIDTH = 32,
  parameter int INNER_WIDTH = 32,
  parameter int NUM_RPORTS = 2,
  parameter bit BYPASS = 1'b1,
  parameter logic [INNER_WIDTH-1:0] INIT_VALUE = '0,
  localparam int IW = $clog2(OUTER_WIDTH)
) (
  input  logic                                  CLK,
  input  logic                                  RST,
  input  logic [NUM_RPORTS-1:0][IW-1:0]          rindex,
  output logic [NUM_RPORTS-1:0][INNER_WIDTH-1:0] rdata,
  input  logic                                  wen,
  input  logic [IW-1:0]                          windex,
  input  logic [INNER_WIDTH-1:0]                 wdata,
  input  logic                                  clear_req,
  output logic                                  clear_busy,
  output logic                                  clear_done
);
  typedef enum logic {IDLE, CLEARING} state_e;
  localparam logic [IW:0] DEPTH = (IW+1)'(OUTER_WIDTH);
  localparam logic [IW-1:0] LAST = IW'(OUTER_WIDTH - 1);
  state_e state_q;
  logic [IW-1:0] cnt_q;
  logic done_q;
  logic [INNER_WIDTH-1:0] mem_q [OUTER_WIDTH];
  logic clearing, wr_ok, last;
  assign clearing = state_q == CLEARING;
  assign last = cnt_q == LAST;
  assign wr_ok = wen && ({1'b0, windex} < DEPTH);
  assign clear_busy = clearing;
  assign clear_done = done_q;
  always_ff @(posedge CLK)
    if (RST) begin
      state_q <= CLEARING;
      cnt_q <= '0;
      done_q <= 1'b0;
    end else if (!clearing) begin
      state_q <= clear_req ? CLEARING : IDLE;
      cnt_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= last ? IDLE : CLEARING;
      cnt_q <= last ? '0 : cnt_q + 1'b1;
      done_q <= last;
    end
  // array has no reset; the sequencer owns the write port while clearing
  always_ff @(posedge CLK)
    if (!RST && clearing) mem_q[cnt_q] <= INIT_VALUE;
    else if (!RST && wr_ok) mem_q[windex] <= wdata;
  always_comb
    for (int p = 0; p < NUM_RPORTS; p++)
      rdata[p] = (RST || clearing || {1'b0, rindex[p]} >= DEPTH) ? INIT_VALUE :
                 (BYPASS && wen && windex == rindex[p]) ? wdata : mem_q[rindex[p]];
endmodule

// File: tb/tb_distram_nrport_1wport_clr.sv
// tb_distram_nrport_1wport_clr: directed scoreboard bench for a 32-deep bypass RAM and a 20-deep no-bypass RAM
module tb_distram_nrport_1wport_clr;
  localparam logic [31:0] INIT_B = 32'hC0DE_0000;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic a_rst = 1'b1, a_wen = 1'b0, a_creq = 1'b0, a_busy, a_done;
  logic [1:0][4:0] a_rindex = '0;
  logic [1:0][31:0] a_rdata;
  logic [4:0] a_windex = '0;
  logic [31:0] a_wdata = '0;

  logic b_rst = 1'b1, b_wen = 1'b0, b_creq = 1'b0, b_busy, b_done;
  logic [1:0][4:0] b_rindex = '0;
  logic [1:0][31:0] b_rdata;
  logic [4:0] b_windex = '0;
  logic [31:0] b_wdata = '0;

  distram_nrport_1wport_clr #(.OUTER_WIDTH(32), .INNER_WIDTH(32), .NUM_RPORTS(2), .BYPASS(1'b1), .INIT_VALUE(32'h0)) u_a (
    .CLK(clk), .RST(a_rst), .rindex(a_rindex), .rdata(a_rdata), .wen(a_wen), .windex(a_windex),
    .wdata(a_wdata), .clear_req(a_creq), .clear_busy(a_busy), .clear_done(a_done));

  distram_nrport_1wport_clr #(.OUTER_WIDTH(20), .INNER_WIDTH(32), .NUM_RPORTS(2), .BYPASS(1'b0), .INIT_VALUE(INIT_B)) u_b (
    .CLK(clk), .RST(b_rst), .rindex(b_rindex), .rdata(b_rdata), .wen(b_wen), .windex(b_windex),
    .wdata(b_wdata), .clear_req(b_creq), .clear_busy(b_busy), .clear_done(b_done));

  typedef struct {string tag; logic [31:0] val;} exp_t;
  exp_t sb[$];
  int n_cmp = 0, n_bad = 0;
  logic [31:0] mdl [32];
  int busy, done, done_at, bad;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string t, input logic [31:0] v);
    exp_t e;
    e.tag = t;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $error("FAIL sb_empty: observed %h, no expected value queued", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_bad++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  // samples once per cycle; optional mid-run write to index 7 and clear_req pulse
  task automatic watch_a(input int n, input int wr_at, input int req_at,
                         output int bc, output int dc, output int da, output int br);
    bc = 0; dc = 0; da = -1; br = 0;
    for (int i = 0; i < n; i++) begin
      a_rindex[0] = 5'($urandom_range(31));
      a_rindex[1] = 5'd7;
      a_wen = (i == wr_at);
      a_windex = 5'd7;
      a_wdata = 32'h77;
      a_creq = (i == req_at);
      #1;
      if (a_busy) begin
        bc++;
        if (a_rdata[0] !== 32'h0 || a_rdata[1] !== 32'h0) br++;
      end
      if (a_done) begin
        dc++;
        if (da < 0) da = i;
      end
      tick();
    end
    a_wen = 1'b0;
    a_creq = 1'b0;
  endtask

  task automatic watch_b(input int n, output int bc, output int dc, output int da, output int br);
    bc = 0; dc = 0; da = -1; br = 0;
    for (int i = 0; i < n; i++) begin
      b_rindex[0] = 5'($urandom_range(31));
      b_rindex[1] = 5'($urandom_range(19));
      #1;
      if (b_busy) begin
        bc++;
        if (b_rdata[0] !== INIT_B || b_rdata[1] !== INIT_B) br++;
      end
      if (b_done) begin
        dc++;
        if (da < 0) da = i;
      end
      tick();
    end
  endtask

  initial begin
    // reset hold and power-on clear
    repeat (3) tick();
    a_rindex = {5'd9, 5'd2};
    #1;
    push("rst_busy", 32'd1); chk(32'(a_busy));
    push("rst_done", 32'd0); chk(32'(a_done));
    push("rst_rdata0", 32'h0); chk(a_rdata[0]);
    push("rst_rdata1", 32'h0); chk(a_rdata[1]);
    a_rst = 1'b0;
    watch_a(40, -1, -1, busy, done, done_at, bad);
    push("init_busy_cycles", 32'd32); chk(32'(busy));
    push("init_done_count", 32'd1); chk(32'(done));
    push("init_done_at", 32'd32); chk(32'(done_at));
    push("init_busy_reads", 32'd0); chk(32'(bad));
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    for (int i = 0; i < 32; i++) begin
      a_rindex = {5'(31 - i), 5'(i)};
      #1;
      push("init_rd", mdl[i]); chk(a_rdata[0]);
    end
    // write with same-cycle bypass
    a_wen = 1'b1; a_windex = 5'd5; a_wdata = 32'hDEADBEEF; a_rindex = {5'd6, 5'd5};
    #1;
    push("byp_p0", 32'hDEADBEEF); chk(a_rdata[0]);
    push("byp_p1", 32'h0); chk(a_rdata[1]);
    tick();
    a_wen = 1'b0;
    #1;
    push("wr_p0", 32'hDEADBEEF); chk(a_rdata[0]);
    // multi-port, same index
    a_wen = 1'b1; a_windex = 5'd31; a_wdata = 32'h1234; a_rindex = {5'd0, 5'd31};
    #1;
    push("mp_byp_p0", 32'h1234); chk(a_rdata[0]);
    push("mp_byp_p1", 32'h0); chk(a_rdata[1]);
    tick();
    a_wen = 1'b0; a_rindex = {5'd31, 5'd31};
    #1;
    push("mp_p0", 32'h1234); chk(a_rdata[0]);
    push("mp_p1", 32'h1234); chk(a_rdata[1]);
    // fill, then clear request alongside a write
    for (int i = 0; i < 32; i++) begin
      a_wen = 1'b1; a_windex = 5'(i); a_wdata = 32'(i + 1);
      tick();
      mdl[i] = 32'(i + 1);
    end
    a_wen = 1'b0;
    for (int i = 0; i < 32; i++) begin
      a_rindex = {5'(31 - i), 5'(i)};
      #1;
      push("fill_p0", mdl[i]); chk(a_rdata[0]);
      push("fill_p1", mdl[31 - i]); chk(a_rdata[1]);
    end
    tick();
    a_creq = 1'b1; a_wen = 1'b1; a_windex = 5'd3; a_wdata = 32'hAA; a_rindex = {5'd4, 5'd3};
    #1;
    push("creq_byp", 32'hAA); chk(a_rdata[0]);
    push("creq_other", 32'd5); chk(a_rdata[1]);
    tick();
    watch_a(40, 20, 10, busy, done, done_at, bad);
    push("clr_busy_cycles", 32'd32); chk(32'(busy));
    push("clr_done_count", 32'd1); chk(32'(done));
    push("clr_done_at", 32'd32); chk(32'(done_at));
    push("clr_busy_reads", 32'd0); chk(32'(bad));
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    for (int i = 0; i < 32; i++) begin
      a_rindex = {5'd7, 5'(i)};
      #1;
      push("clr_rd", mdl[i]); chk(a_rdata[0]);
    end
    push("clr_rd7", mdl[7]); chk(a_rdata[1]);
    // reset in the middle of a clear
    tick();
    a_creq = 1'b1;
    tick();
    a_creq = 1'b0;
    watch_a(10, -1, -1, busy, done, done_at, bad);
    push("abort_busy", 32'd10); chk(32'(busy));
    push("abort_done", 32'd0); chk(32'(done));
    a_rst = 1'b1;
    tick();
    a_rst = 1'b0;
    watch_a(40, -1, -1, busy, done, done_at, bad);
    push("restart_busy", 32'd32); chk(32'(busy));
    push("restart_done", 32'd1); chk(32'(done));
    push("restart_done_at", 32'd32); chk(32'(done_at));
    // 20-deep, no bypass, non-zero INIT_VALUE
    b_rst = 1'b0;
    watch_b(30, busy, done, done_at, bad);
    push("b_busy_cycles", 32'd20); chk(32'(busy));
    push("b_done_count", 32'd1); chk(32'(done));
    push("b_done_at", 32'd20); chk(32'(done_at));
    push("b_busy_reads", 32'd0); chk(32'(bad));
    b_wen = 1'b1; b_windex = 5'd5; b_wdata = 32'hDEADBEEF; b_rindex = {5'd6, 5'd5};
    #1;
    push("b_nobyp_p0", INIT_B); chk(b_rdata[0]);
    push("b_nobyp_p1", INIT_B); chk(b_rdata[1]);
    tick();
    b_wen = 1'b0;
    #1;
    push("b_wr_p0", 32'hDEADBEEF); chk(b_rdata[0]);
    push("b_wr_p1", INIT_B); chk(b_rdata[1]);
    b_wen = 1'b1; b_windex = 5'd25; b_wdata = 32'h1111; b_rindex = {5'd19, 5'd25};
    #1;
    push("b_oor_p0", INIT_B); chk(b_rdata[0]);
    push("b_last_p1", INIT_B); chk(b_rdata[1]);
    tick();
    b_wen = 1'b0; b_rindex = {5'd5, 5'd25};
    #1;
    push("b_oor_after", INIT_B); chk(b_rdata[0]);
    push("b_keep5", 32'hDEADBEEF); chk(b_rdata[1]);
    push("b_idle", 32'd0); chk(32'(b_busy));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/distram_nrport_1wport_clr.md
Name: distram_nrport_1wport_clr

Overview:
- Parametrised distributed-RAM array: NUM_RPORTS asynchronous read ports and one synchronous write port.
- Optional same-cycle write-to-read bypass.
- Built-in clear sequencer writes INIT_VALUE to every entry after reset and on request.
- Successor to the 1R/1W distram; used for core tables (maps, predictor state) that need multiple lookups per cycle and a bulk clear.

Parameters:
- OUTER_WIDTH, 32, number of entries (need not be a power of two; must be >= 2).
- INNER_WIDTH, 32, bits per entry.
- NUM_RPORTS, 2, number of read ports (>= 1).
- BYPASS, 1, 1 = read sees same-cycle write data; 0 = read sees array contents only.
- INIT_VALUE, '0, INNER_WIDTH-bit value written by the clear sequencer.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset.
- rindex  in  NUM_RPORTS x $clog2(OUTER_WIDTH)  read index per port.
- rdata  out  NUM_RPORTS x INNER_WIDTH  read data per port (combinational).
- wen  in  1  write enable.
- windex  in  $clog2(OUTER_WIDTH)  write index.
- wdata  in  INNER_WIDTH  write data.
- clear_req  in  1  request a full-array clear.
- clear_busy  out  1  clear sequence in progress.
- clear_done  out  1  one-cycle pulse, first cycle after a clear completes.

Behaviour:
- Clock and reset: one clock, CLK. Reset is synchronous and active-high, port RST.
- Reset values: state=CLEARING, clear counter=0, clear_busy=1, clear_done=0. The array itself has no reset; it is initialised by the sequencer.
- While RST is high:
  - No array writes occur.
  - Counter is held at 0.
  - rdata = INIT_VALUE on all ports.
- FSM states: IDLE, CLEARING.
- IDLE:
  - If wen=1 and windex<OUTER_WIDTH, array[windex] <= wdata at posedge.
  - If windex>=OUTER_WIDTH, the write is dropped.
  - If clear_req=1, go to CLEARING with counter=0 next cycle. wen in that same cycle is still performed.
- CLEARING:
  - Each cycle: array[counter] <= INIT_VALUE, counter++.
  - When counter==OUTER_WIDTH-1, that final write occurs, next state=IDLE, counter=0.
  - The clear takes exactly OUTER_WIDTH cycles.
  - External wen is ignored (write dropped).
  - clear_req is ignored; no restart.
  - All rdata = INIT_VALUE regardless of rindex, so the array reads as logically cleared for the whole sequence.
- clear_busy = (state==CLEARING), decoded from the state register.
- clear_done: registered. It is 1 in the first IDLE cycle after CLEARING completes, otherwise 0. It is not asserted if RST interrupts a clear.
- RST mid-clear: aborts the clear and restarts from counter=0 after RST falls.
- Read in IDLE, per port p:
  - If rindex[p]>=OUTER_WIDTH: rdata[p]=INIT_VALUE.
  - Else if BYPASS=1 and wen=1 and windex==rindex[p]: rdata[p]=wdata (same cycle).
  - Else: rdata[p]=array[rindex[p]].
- Multiple ports reading the same index all return identical data, including the bypass case.
- Write latency: the written value is visible via the array on the cycle after the posedge. With BYPASS=1 it is also visible in the write cycle itself.
- Counter width: $clog2(OUTER_WIDTH). Wrap is by compare to OUTER_WIDTH-1, never by natural overflow.

Test Plan:
- Reset/init: hold RST 3 cycles, release, OUTER_WIDTH=32 -> clear_busy=1 for exactly 32 cycles, clear_done=1 on cycle 33 only. All rdata=0 throughout; array reads 0 at every index afterwards.
- Write/read + bypass: IDLE, wen=1, windex=5, wdata=0xDEADBEEF, rindex={5,6}:
  - BYPASS=1 -> rdata[0]=0xDEADBEEF in the same cycle, rdata[1]=0.
  - BYPASS=0 -> rdata[0]=0 in that cycle, 0xDEADBEEF the next cycle.
- Multi-port same index: write 0x1234 to index 31. Next cycle rindex={31,31} -> both rdata=0x1234. Same cycle with rindex={31,0} -> {0x1234, 0}.
- Clear request with traffic: fill indices 0..31 with index+1, pulse clear_req together with wen=1, windex=3, wdata=0xAA:
  - Index 3 is written 0xAA, then the clear runs 32 cycles.
  - wen to index 7 mid-clear is dropped; rdata reads INIT_VALUE while busy.
  - A second clear_req mid-clear does not extend the clear.
  - After clear_done, all entries = 0.
- Reset mid-clear: assert RST at clear cycle 10 for 1 cycle -> clear_done not pulsed; a fresh 32-cycle clear follows; clear_done fires once at its end.
- Non-power-of-two depth: OUTER_WIDTH=20 -> clear lasts 20 cycles. windex=25 write is dropped; rindex=25 returns INIT_VALUE; counter never exceeds 19.
